// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned display commits.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module hex_display_scanner #(
  parameter int DIGITS      = 4,
  parameter int CLK_DIV     = 4,
  parameter int DEAD_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic                  blank_i,
  output logic [0:6]            seg_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
  localparam int DIVW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [DIVW-1:0] DRIVE_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] DEAD_LAST  = DIVW'(DEAD_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DIGITS - 1);

  typedef enum logic {ST_DRIVE, ST_DEAD} state_e;

  state_e                state_q;
  logic [DIVW-1:0]       div_q;
  logic [IDXW-1:0]       idx_q;
  logic                  primed_q;
  logic [4*DIGITS-1:0]   pending_q;
  logic [4*DIGITS-1:0]   disp_q;
  logic [0:6]            seg_q;
  logic [DIGITS-1:0]     an_q;

  logic [IDXW-1:0]       idx_d;
  logic                  dead_exit;
  logic                  commit;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     an_drive;
  logic                  lz_suppress;

  function automatic logic [0:6] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b0000001;
      4'h1: enc = 7'b1001111;
      4'h2: enc = 7'b0010010;
      4'h3: enc = 7'b0000110;
      4'h4: enc = 7'b1001100;
      4'h5: enc = 7'b0100100;
      4'h6: enc = 7'b0100000;
      4'h7: enc = 7'b0001111;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0001100;
      4'hA: enc = 7'b0001000;
      4'hB: enc = 7'b1100000;
      4'hC: enc = 7'b0110001;
      4'hD: enc = 7'b1000010;
      4'hE: enc = 7'b0110000;
      default: enc = 7'b0111000;
    endcase
  endfunction

  // The first dead-time exit after reset lands on digit 0 instead of advancing.
  always_comb begin
    idx_d = '0;
    if (primed_q && idx_q != IDX_LAST) idx_d = idx_q + 1'b1;
    dead_exit = (state_q == ST_DEAD) && (div_q == DEAD_LAST);
    commit    = dead_exit && (idx_d == '0);
  end

  always_comb begin
    nib      = 4'h0;
    an_drive = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib         = disp_q[4*i +: 4];
        an_drive[i] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;
  always_comb begin
    lz_suppress = 1'b0;
    upper_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'h0);
      if (idx_q == IDXW'(i)) lz_suppress = upper_zero;
    end
  end
`else
  assign lz_suppress = 1'b0;
`endif

  // Gated so the commit condition held during reset never shows as a frame pulse.
  assign frame_o = commit & ~rst_i;
  assign seg_o   = seg_q;
  assign an_o    = an_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_DEAD;
      div_q     <= '0;
      idx_q     <= '0;
      primed_q  <= 1'b0;
      pending_q <= '0;
      disp_q    <= '0;
      seg_q     <= 7'b1111111;
      an_q      <= '1;
    end else begin
      if (load_i) pending_q <= value_i;
      if (commit) disp_q <= load_i ? value_i : pending_q;

      case (state_q)
        ST_DRIVE: begin
          if (div_q == DRIVE_LAST) begin
            state_q <= ST_DEAD;
            div_q   <= '0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: begin
          if (dead_exit) begin
            state_q  <= ST_DRIVE;
            div_q    <= '0;
            idx_q    <= idx_d;
            primed_q <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      endcase

      if (blank_i || state_q == ST_DEAD || lz_suppress) begin
        an_q  <= '1;
        seg_q <= 7'b1111111;
      end else begin
        an_q  <= an_drive;
        seg_q <= enc(nib);
      end
    end
  end

endmodule
